// File: rtl/uart_rx.sv
// UART receiver: two-flop input synchroniser, mid-bit sampling FSM and a
// single-entry valid/ready output holding the word and its error flags.
module uart_rx #(
  parameter int ClockDivider = 8,
  parameter int DataBits     = 8,
  parameter int StopBits     = 1,
  parameter int ParityBits   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_bit,
  output logic [DataBits-1:0] data_out,
  output logic                data_out_valid,
  input  logic                data_out_ready,
  output logic                parity_error,
  output logic                frame_error,
  output logic                overrun
);

  // state  | meaning
  // IDLE   | line idle, waiting for a low level on rx_s
  // START  | timing to the middle of the start bit, rejecting glitches
  // DATA   | sampling DataBits data bits, LSB first
  // PARITY | sampling the even-parity bit
  // STOP   | sampling StopBits stop bits, then delivering the word

  if (ClockDivider < 4 || (ClockDivider % 2) != 0) begin : g_bad_divider
    $error("uart_rx: ClockDivider must be >= 4 and even");
  end
  if (DataBits < 5 || DataBits > 9) begin : g_bad_databits
    $error("uart_rx: DataBits must be in [5,9]");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_bad_stopbits
    $error("uart_rx: StopBits must be 1 or 2");
  end
  if (ParityBits < 0 || ParityBits > 1) begin : g_bad_paritybits
    $error("uart_rx: ParityBits must be 0 or 1");
  end

  localparam int CW = $clog2(ClockDivider);
  localparam int IW = 4;
  localparam logic [CW-1:0] CNT_LAST  = CW'(ClockDivider - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(ClockDivider / 2 - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DataBits - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(StopBits - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state, state_nxt;
  logic                sync_q, rx_s;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [DataBits-1:0] shreg;
  logic                par_flag, frm_flag;
  logic                mid_bit, frame_done, frm_final, load, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (cnt == CNT_HALF) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (mid_bit && idx == DATA_LAST) state_nxt = (ParityBits != 0) ? PARITY : STOP;
      PARITY:  if (mid_bit) state_nxt = STOP;
      STOP:    if (mid_bit && idx == STOP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mid_bit    = (cnt == CNT_LAST);
    frame_done = (state == STOP) && mid_bit && (idx == STOP_LAST);
    frm_final  = frm_flag | ~rx_s;
    load       = frame_done && (!data_out_valid || data_out_ready);
    drop       = frame_done && data_out_valid && !data_out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q         <= 1'b1;
      rx_s           <= 1'b1;
      cnt            <= '0;
      idx            <= '0;
      shreg          <= '0;
      par_flag       <= 1'b0;
      frm_flag       <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      parity_error   <= 1'b0;
      frame_error    <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      sync_q  <= in_bit;
      rx_s    <= sync_q;
      overrun <= drop;

      if (state == IDLE || state != state_nxt || mid_bit) cnt <= '0;
      else                                                cnt <= cnt + CW'(1);

      case (state)
        IDLE: begin
          idx <= '0;
          if (!rx_s) begin
            par_flag <= 1'b0;
            frm_flag <= 1'b0;
          end
        end
        START: idx <= '0;
        DATA: if (mid_bit) begin
          // Right shift: after DataBits samples the first bit sits at bit 0.
          shreg <= {rx_s, shreg[DataBits-1:1]};
          idx   <= (idx == DATA_LAST) ? '0 : idx + IW'(1);
        end
        PARITY: if (mid_bit) par_flag <= (rx_s != ^shreg);
        STOP: if (mid_bit) begin
          if (!rx_s) frm_flag <= 1'b1;
          idx <= (idx == STOP_LAST) ? '0 : idx + IW'(1);
        end
        default: idx <= '0;
      endcase

      if (load) begin
        data_out       <= shreg;
        parity_error   <= par_flag;
        frame_error    <= frm_final;
        data_out_valid <= 1'b1;
      end else if (data_out_ready) begin
        data_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1, 8E1 and 8N2 instances share one serial line;
// each test resets them and checks only the instance matching its frame format.
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_bit, ready;
  logic [7:0] d_a, d_b, d_c;
  logic v_a, pe_a, fe_a, ov_a;
  logic v_b, pe_b, fe_b, ov_b;
  logic v_c, pe_c, fe_c, ov_c;

  uart_rx #(.ClockDivider(8), .DataBits(8), .StopBits(1), .ParityBits(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .data_out(d_a), .data_out_valid(v_a),
    .data_out_ready(ready), .parity_error(pe_a), .frame_error(fe_a), .overrun(ov_a));
  uart_rx #(.ClockDivider(8), .DataBits(8), .StopBits(1), .ParityBits(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .data_out(d_b), .data_out_valid(v_b),
    .data_out_ready(ready), .parity_error(pe_b), .frame_error(fe_b), .overrun(ov_b));
  uart_rx #(.ClockDivider(8), .DataBits(8), .StopBits(2), .ParityBits(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .data_out(d_c), .data_out_valid(v_c),
    .data_out_ready(ready), .parity_error(pe_c), .frame_error(fe_c), .overrun(ov_c));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observer for the 8N1 instance: accepted words, overrun cycles, valid rise time.
  int acc_a = 0;
  int ov_cnt_a = 0;
  int rise_a = 0;
  logic [7:0] acc_a_data = '0;
  logic acc_a_pe = 1'b0, acc_a_fe = 1'b0, v_a_q = 1'b0;
  always @(negedge clk) begin
    #1;
    if (v_a && !v_a_q) rise_a = cyc;
    v_a_q = v_a;
    if (v_a && ready) begin
      acc_a++;
      acc_a_data = d_a;
      acc_a_pe = pe_a;
      acc_a_fe = fe_a;
    end
    if (ov_a) ov_cnt_a++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    in_bit = 1'b1;
    ready = 1'b0;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(4);
  endtask

  // 8 clk per bit; called just after a falling clock edge.
  task automatic send_frame(input logic [7:0] d, input bit par_en, input bit par_v,
                            input int nstop, input logic [1:0] stops);
    logic [7:0] sh;
    sh = d;
    in_bit = 1'b0;
    start_cyc = cyc;
    idle(8);
    for (int i = 0; i < 8; i++) begin
      in_bit = sh[0];
      sh = sh >> 1;
      idle(8);
    end
    if (par_en) begin
      in_bit = par_v;
      idle(8);
    end
    for (int i = 0; i < nstop; i++) begin
      in_bit = (i == 0) ? stops[0] : stops[1];
      idle(8);
    end
    in_bit = 1'b1;
  endtask

  task automatic test_reset();
    in_bit = 1'b1;
    ready = 1'b0;
    rst_n = 1'b0;
    idle(2);
    checks++; if (v_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", v_a); end
    checks++; if (d_a !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", d_a); end
    checks++; if (pe_a !== 1'b0) begin errors++; $display("FAIL reset_parity got %b exp 0", pe_a); end
    checks++; if (fe_a !== 1'b0) begin errors++; $display("FAIL reset_frame got %b exp 0", fe_a); end
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", ov_a); end
    checks++; if ({v_b, v_c} !== 2'b00) begin errors++; $display("FAIL reset_valid_bc got %b exp 00", {v_b, v_c}); end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    int base, base_ov, lat;
    do_reset();
    ready = 1'b1;
    base = acc_a;
    base_ov = ov_cnt_a;
    send_frame(8'hA5, 1'b0, 1'b0, 1, 2'b11);
    idle(8);
    lat = rise_a - start_cyc;
    checks++; if (acc_a - base !== 1) begin errors++; $display("FAIL basic_count got %0d exp 1", acc_a - base); end
    checks++; if (acc_a_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", acc_a_data); end
    checks++; if (acc_a_pe !== 1'b0) begin errors++; $display("FAIL basic_parity got %b exp 0", acc_a_pe); end
    checks++; if (acc_a_fe !== 1'b0) begin errors++; $display("FAIL basic_frame got %b exp 0", acc_a_fe); end
    checks++; if (ov_cnt_a - base_ov !== 0) begin errors++; $display("FAIL basic_overrun got %0d exp 0", ov_cnt_a - base_ov); end
    checks++; if (lat < 78 || lat > 80) begin errors++; $display("FAIL basic_latency got %0d exp 79", lat); end
    checks++; if (v_a !== 1'b0) begin errors++; $display("FAIL basic_valid_clear got %b exp 0", v_a); end
  endtask

  task automatic test_glitch();
    int base;
    do_reset();
    ready = 1'b1;
    base = acc_a;
    in_bit = 1'b0;
    idle(3);
    in_bit = 1'b1;
    idle(40);
    checks++; if (acc_a - base !== 0) begin errors++; $display("FAIL glitch_count got %0d exp 0", acc_a - base); end
    checks++; if ({v_a, pe_a, fe_a} !== 3'b000) begin errors++; $display("FAIL glitch_flags got %b exp 000", {v_a, pe_a, fe_a}); end
    send_frame(8'h3C, 1'b0, 1'b0, 1, 2'b11);
    idle(8);
    checks++; if (acc_a - base !== 1) begin errors++; $display("FAIL glitch_next_count got %0d exp 1", acc_a - base); end
    checks++; if (acc_a_data !== 8'h3C) begin errors++; $display("FAIL glitch_next_data got %h exp 3c", acc_a_data); end
    checks++; if (acc_a_fe !== 1'b0) begin errors++; $display("FAIL glitch_next_frame got %b exp 0", acc_a_fe); end
  endtask

  task automatic test_parity();
    do_reset();
    send_frame(8'h07, 1'b1, 1'b0, 1, 2'b11);
    idle(4);
    checks++; if (v_b !== 1'b1) begin errors++; $display("FAIL parity_bad_valid got %b exp 1", v_b); end
    checks++; if (d_b !== 8'h07) begin errors++; $display("FAIL parity_bad_data got %h exp 07", d_b); end
    checks++; if (pe_b !== 1'b1) begin errors++; $display("FAIL parity_bad_flag got %b exp 1", pe_b); end
    checks++; if (fe_b !== 1'b0) begin errors++; $display("FAIL parity_bad_frame got %b exp 0", fe_b); end
    do_reset();
    send_frame(8'h07, 1'b1, 1'b1, 1, 2'b11);
    idle(4);
    checks++; if (v_b !== 1'b1) begin errors++; $display("FAIL parity_ok_valid got %b exp 1", v_b); end
    checks++; if (pe_b !== 1'b0) begin errors++; $display("FAIL parity_ok_flag got %b exp 0", pe_b); end
  endtask

  task automatic test_frame_error();
    do_reset();
    send_frame(8'h81, 1'b0, 1'b0, 1, 2'b00);
    idle(4);
    checks++; if (v_a !== 1'b1) begin errors++; $display("FAIL frame1_valid got %b exp 1", v_a); end
    checks++; if (d_a !== 8'h81) begin errors++; $display("FAIL frame1_data got %h exp 81", d_a); end
    checks++; if (fe_a !== 1'b1) begin errors++; $display("FAIL frame1_flag got %b exp 1", fe_a); end
    checks++; if (pe_a !== 1'b0) begin errors++; $display("FAIL frame1_parity got %b exp 0", pe_a); end
    do_reset();
    send_frame(8'h81, 1'b0, 1'b0, 2, 2'b01);
    idle(4);
    checks++; if (v_c !== 1'b1) begin errors++; $display("FAIL frame2_valid got %b exp 1", v_c); end
    checks++; if (d_c !== 8'h81) begin errors++; $display("FAIL frame2_data got %h exp 81", d_c); end
    checks++; if (fe_c !== 1'b1) begin errors++; $display("FAIL frame2_flag got %b exp 1", fe_c); end
    do_reset();
    send_frame(8'h81, 1'b0, 1'b0, 2, 2'b11);
    idle(4);
    checks++; if (fe_c !== 1'b0) begin errors++; $display("FAIL frame2_clean_flag got %b exp 0", fe_c); end
  endtask

  task automatic test_overrun();
    int base, base_ov;
    do_reset();
    base = acc_a;
    base_ov = ov_cnt_a;
    send_frame(8'h11, 1'b0, 1'b0, 1, 2'b11);
    send_frame(8'h22, 1'b0, 1'b0, 1, 2'b11);
    idle(8);
    checks++; if (v_a !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", v_a); end
    checks++; if (d_a !== 8'h11) begin errors++; $display("FAIL ovr_data got %h exp 11", d_a); end
    checks++; if (ov_cnt_a - base_ov !== 1) begin errors++; $display("FAIL ovr_pulse_cycles got %0d exp 1", ov_cnt_a - base_ov); end
    checks++; if (acc_a - base !== 0) begin errors++; $display("FAIL ovr_accepts got %0d exp 0", acc_a - base); end
  endtask

  task automatic test_back_to_back();
    int base, base_ov;
    do_reset();
    send_frame(8'h11, 1'b0, 1'b0, 1, 2'b11);
    base = acc_a;
    base_ov = ov_cnt_a;
    // Ready only in the cycle of the 0x22 last stop-bit sample (valid rises at +79).
    fork
      send_frame(8'h22, 1'b0, 1'b0, 1, 2'b11);
      begin
        idle(78);
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
      end
    join
    idle(8);
    checks++; if (acc_a - base !== 1) begin errors++; $display("FAIL b2b_accepts got %0d exp 1", acc_a - base); end
    checks++; if (acc_a_data !== 8'h11) begin errors++; $display("FAIL b2b_accepted_data got %h exp 11", acc_a_data); end
    checks++; if (v_a !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", v_a); end
    checks++; if (d_a !== 8'h22) begin errors++; $display("FAIL b2b_data got %h exp 22", d_a); end
    checks++; if (ov_cnt_a - base_ov !== 0) begin errors++; $display("FAIL b2b_overrun got %0d exp 0", ov_cnt_a - base_ov); end
  endtask

  task automatic test_reset_midframe();
    int base;
    do_reset();
    send_frame(8'h33, 1'b0, 1'b0, 1, 2'b11);
    idle(2);
    checks++; if (v_a !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b exp 1", v_a); end
    fork
      send_frame(8'h99, 1'b0, 1'b0, 1, 2'b11);
      begin
        idle(44);
        rst_n = 1'b0;
        #1;
        checks++; if (v_a !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b exp 0", v_a); end
        checks++; if (d_a !== 8'h00) begin errors++; $display("FAIL rst_async_data got %h exp 00", d_a); end
      end
    join
    rst_n = 1'b1;
    idle(16);
    checks++; if (v_a !== 1'b0) begin errors++; $display("FAIL rst_no_partial got %b exp 0", v_a); end
    ready = 1'b1;
    base = acc_a;
    send_frame(8'h5A, 1'b0, 1'b0, 1, 2'b11);
    idle(8);
    checks++; if (acc_a - base !== 1) begin errors++; $display("FAIL rst_next_count got %0d exp 1", acc_a - base); end
    checks++; if (acc_a_data !== 8'h5A) begin errors++; $display("FAIL rst_next_data got %h exp 5a", acc_a_data); end
    checks++; if (acc_a_fe !== 1'b0) begin errors++; $display("FAIL rst_next_frame got %b exp 0", acc_a_fe); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver; the receive-side counterpart of the team's UART transmitter, sharing its frame parameters.
- Consumes the asynchronous serial line and synchronises it.
- Samples each bit at mid-period and delivers one word per frame on a valid/ready output port.
- Each word carries parity-error and framing-error flags.
- Sits between the pad/loopback line and the CPU's MMIO UART register block.

Parameters:
- ClockDivider, 8: clk cycles per bit period; must be >= 4 and even, else $error at elaboration.
- DataBits, 8: data bits per frame; legal range [5,9].
- StopBits, 1: stop bits per frame; 1 or 2.
- ParityBits, 0: 0 = no parity bit; 1 = one even-parity bit (expected value = XOR of data bits).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous assert, active-low
- in_bit  input  1  serial line, asynchronous to clk, idles high
- data_out  output  DataBits  received word; bit 0 is the first data bit on the line (LSB first)
- data_out_valid  output  1  data_out and the error flags hold a word not yet accepted
- data_out_ready  input  1  consumer accepts the word in any cycle where valid && ready
- parity_error  output  1  parity mismatch for the held word; meaningful only while data_out_valid
- frame_error  output  1  at least one stop bit sampled 0 for the held word; meaningful only while data_out_valid
- overrun  output  1  one-cycle pulse: a completed frame was dropped because the output was full

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
  - Synchroniser flops reset to 1 and the FSM goes to IDLE.
  - Divider counter and bit index reset to 0.
  - data_out_valid = 0, data_out = 0, parity_error = 0, frame_error = 0, overrun = 0.
  - Asserting rst_n mid-frame aborts the frame; no partial word is ever delivered.
- Input synchroniser: two flops; rx_s is the second-stage output, so rx_s lags in_bit by 2 clk.
- Frame on the line: start (0), then DataBits data bits LSB first, then the parity bit if ParityBits = 1, then StopBits stop bits (1).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on rx_s == 0, go to START with counter = 0.
  - START: counter increments each clk. At counter == ClockDivider/2 - 1 (mid start bit), sample rx_s:
    - rx_s == 1: glitch, return to IDLE; nothing is delivered and no flag is set.
    - rx_s == 0: go to DATA with counter = 0 and bit index = 0.
  - DATA: counter runs 0 .. ClockDivider-1 and wraps to 0. On the wrap cycle (counter == ClockDivider-1, mid-bit), shift rx_s into the shift register at position bit index, then increment bit index. After DataBits samples, go to PARITY if ParityBits = 1, else STOP.
  - PARITY: one mid-bit sample. Set the internal parity flag if rx_s != XOR of the data bits. Then go to STOP.
  - STOP: StopBits mid-bit samples. Any sample equal to 0 sets the internal frame flag. After the last stop sample, the frame is complete; return to IDLE in the same transition.
    - The remaining half of the stop bit is spent in IDLE, so a start bit that immediately follows is detected.
- Delivery on frame complete (cycle C = last stop-bit sample):
  - If data_out_valid == 0, or data_out_ready == 1 in cycle C: at the C+1 edge load data_out and both error flags, and set data_out_valid = 1. A simultaneous accept of the old word is legal and lossless.
  - Otherwise: keep the held word and its flags unchanged, discard the new frame, and assert overrun for exactly one cycle at C+1.
- Handshake: data_out_valid stays high until valid && ready, then clears at the next edge unless a new frame is loaded at that same edge. data_out, parity_error and frame_error are stable while valid.
- Frames with errors are still delivered, carrying their flags.
- Latency: from the in_bit falling edge to data_out_valid = 2 (sync) + 1 (IDLE detect) + ClockDivider/2 + ClockDivider*(DataBits+ParityBits+StopBits) clk, within ±1 clk.
- A line stuck low: after a frame-error delivery the FSM sees 0 in IDLE and re-enters START. This is required; do not add break detection.

Test Plan:
- 8N1, divider 8: send 0xA5 (line 0,1,0,1,0,0,1,0,1,1), ready held 1 -> one valid pulse with data_out = 0xA5, parity_error = 0, frame_error = 0, overrun never.
- Glitch: in_bit low for 3 clk then high, divider 8 -> FSM returns to IDLE, no valid, no flags; a following 0x3C frame is received correctly.
- ParityBits = 1: send 0x07 with parity bit 0 (expected 1) -> data_out = 0x07, parity_error = 1; then 0x07 with parity 1 -> parity_error = 0.
- Frame error: send 0x81 with stop bit forced 0 -> data_out = 0x81, frame_error = 1; StopBits = 2 with only the second stop bit 0 -> frame_error = 1.
- Overrun: ready held 0, send 0x11 then 0x22 back-to-back -> data_out stays 0x11, overrun pulses exactly 1 cycle. Repeat with ready asserted in the completion cycle of 0x22 -> 0x11 accepted, 0x22 loaded, no overrun.
- Reset: drop rst_n during data bit 4 of a frame -> valid = 0 immediately; after release, the next full frame 0x5A is received correctly.
